// File: rtl/rob_controller.sv
// Reorder-buffer controller: in-order index allocation, out-of-order completion,
// in-order retire to the register file or store release, and exception/flush wipe.
module rob_controller #(
  parameter int unsigned ENTRIES = 10,
  parameter int unsigned IDX_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_allocate,
  input  logic [4:0]        in_alloc_rd,
  input  logic              in_alloc_is_store,
  input  logic [31:0]       in_alloc_pc,
  output logic [IDX_W-1:0]  out_alloc_idx,
  output logic              out_full,
  output logic              out_stall,
  output logic              out_empty,
  output logic [IDX_W:0]    out_count,
  input  logic              in_complete,
  input  logic [IDX_W-1:0]  in_complete_idx,
  input  logic [31:0]       in_complete_data,
  input  logic [2:0]        in_complete_exception,
  input  logic              in_flush,
  output logic              out_rf_write_enable,
  output logic [4:0]        out_rf_write_reg,
  output logic [31:0]       out_rf_write_data,
  output logic              out_store_commit,
  output logic [IDX_W-1:0]  out_commit_idx,
  output logic              out_exception,
  output logic [2:0]        out_exception_vector,
  output logic [31:0]       out_exception_pc
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRIES);

  // Per-entry state
  logic        valid_q    [ENTRIES];
  logic        done_q     [ENTRIES];
  logic [4:0]  rd_q       [ENTRIES];
  logic        is_store_q [ENTRIES];
  logic [31:0] pc_q       [ENTRIES];
  logic [31:0] data_q     [ENTRIES];
  logic [2:0]  exc_q      [ENTRIES];

  logic [IDX_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic             full;
  logic             head_ready;
  logic             head_exc;
  logic             clear;
  logic             retire;
  logic             alloc_ok;
  logic             cmpl_in_range;
  logic             cmpl_ok;
  logic [IDX_W-1:0] head_d, tail_d;
  logic [CNT_W-1:0] count_d;

  // Pointers wrap at ENTRIES, which need not be a power of two
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + IDX_W'(1);
  endfunction

  assign full          = (count_q == FULL_CNT);
  assign out_full      = full;
  assign out_stall     = in_allocate & full;
  assign out_empty     = (count_q == '0);
  assign out_count     = count_q;
  assign out_alloc_idx = tail_q;
  assign cmpl_in_range = ({1'b0, in_complete_idx} < FULL_CNT);

  // Retire/clear decisions and pointer/count next state
  always_comb begin
    head_ready = valid_q[head_q] & done_q[head_q];
    head_exc   = head_ready & (exc_q[head_q] != 3'd0);
    clear      = in_flush | head_exc;
    retire     = head_ready & ~clear;
    alloc_ok   = in_allocate & ~full & ~clear;
    cmpl_ok    = in_complete & cmpl_in_range & ~clear;
    if (cmpl_ok) begin
      cmpl_ok = valid_q[in_complete_idx];
    end

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (retire) head_d = wrap_inc(head_q);
      if (alloc_ok) tail_d = wrap_inc(tail_q);
      case ({alloc_ok, retire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Entry storage, pointers and registered retire/exception outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]    <= 1'b0;
        done_q[i]     <= 1'b0;
        rd_q[i]       <= '0;
        is_store_q[i] <= 1'b0;
        pc_q[i]       <= '0;
        data_q[i]     <= '0;
        exc_q[i]      <= '0;
      end
      head_q               <= '0;
      tail_q               <= '0;
      count_q              <= '0;
      out_rf_write_enable  <= 1'b0;
      out_rf_write_reg     <= '0;
      out_rf_write_data    <= '0;
      out_store_commit     <= 1'b0;
      out_commit_idx       <= '0;
      out_exception        <= 1'b0;
      out_exception_vector <= '0;
      out_exception_pc     <= '0;
    end else begin
      out_rf_write_enable <= 1'b0;
      out_store_commit    <= 1'b0;
      out_exception       <= 1'b0;
      head_q              <= head_d;
      tail_q              <= tail_d;
      count_q             <= count_d;

      if (clear) begin
        for (int i = 0; i < int'(ENTRIES); i++) begin
          valid_q[i] <= 1'b0;
          done_q[i]  <= 1'b0;
        end
        if (head_exc) begin
          out_exception        <= 1'b1;
          out_exception_vector <= exc_q[head_q];
          out_exception_pc     <= pc_q[head_q];
        end
      end else begin
        if (cmpl_ok) begin
          done_q[in_complete_idx] <= 1'b1;
          data_q[in_complete_idx] <= in_complete_data;
          exc_q[in_complete_idx]  <= in_complete_exception;
        end
        if (alloc_ok) begin
          valid_q[tail_q]    <= 1'b1;
          done_q[tail_q]     <= 1'b0;
          rd_q[tail_q]       <= in_alloc_rd;
          is_store_q[tail_q] <= in_alloc_is_store;
          pc_q[tail_q]       <= in_alloc_pc;
        end
        // Placed last so a same-cycle completion to the retiring head cannot revive it
        if (retire) begin
          valid_q[head_q]     <= 1'b0;
          done_q[head_q]      <= 1'b0;
          out_commit_idx      <= head_q;
          out_rf_write_enable <= ~is_store_q[head_q] & (rd_q[head_q] != 5'd0);
          out_rf_write_reg    <= rd_q[head_q];
          out_rf_write_data   <= data_q[head_q];
          out_store_commit    <= is_store_q[head_q];
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_controller.sv
// Scoreboard bench for rob_controller: expected retire strobes are queued as
// stimulus is planned and checked by a negedge monitor as the DUT emits them.
module tb_rob_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_allocate;
  logic [4:0]  in_alloc_rd;
  logic        in_alloc_is_store;
  logic [31:0] in_alloc_pc;
  logic [3:0]  out_alloc_idx;
  logic        out_full;
  logic        out_stall;
  logic        out_empty;
  logic [4:0]  out_count;
  logic        in_complete;
  logic [3:0]  in_complete_idx;
  logic [31:0] in_complete_data;
  logic [2:0]  in_complete_exception;
  logic        in_flush;
  logic        out_rf_write_enable;
  logic [4:0]  out_rf_write_reg;
  logic [31:0] out_rf_write_data;
  logic        out_store_commit;
  logic [3:0]  out_commit_idx;
  logic        out_exception;
  logic [2:0]  out_exception_vector;
  logic [31:0] out_exception_pc;

  rob_controller #(.ENTRIES(10), .IDX_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_allocate(in_allocate), .in_alloc_rd(in_alloc_rd),
    .in_alloc_is_store(in_alloc_is_store), .in_alloc_pc(in_alloc_pc),
    .out_alloc_idx(out_alloc_idx), .out_full(out_full), .out_stall(out_stall),
    .out_empty(out_empty), .out_count(out_count),
    .in_complete(in_complete), .in_complete_idx(in_complete_idx),
    .in_complete_data(in_complete_data), .in_complete_exception(in_complete_exception),
    .in_flush(in_flush),
    .out_rf_write_enable(out_rf_write_enable), .out_rf_write_reg(out_rf_write_reg),
    .out_rf_write_data(out_rf_write_data), .out_store_commit(out_store_commit),
    .out_commit_idx(out_commit_idx), .out_exception(out_exception),
    .out_exception_vector(out_exception_vector), .out_exception_pc(out_exception_pc)
  );

  always #5 clk = ~clk;

  // kind: 0 = RF write, 1 = store release, 2 = exception
  typedef struct {
    int          kind;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [3:0]  idx;
    logic [2:0]  vec;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   strobe_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  // Monitor: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    int   kind_act;
    int   nstrobe;
    if (reset && (out_rf_write_enable || out_store_commit || out_exception)) begin
      strobe_cyc.push_back(cyc);
      nstrobe = int'(out_rf_write_enable) + int'(out_store_commit) + int'(out_exception);
      kind_act = out_exception ? 2 : (out_store_commit ? 1 : 0);
      checks++;
      if (nstrobe != 1) begin
        errors++;
        $display("FAIL strobe_onehot: got %0d strobes, required 1", nstrobe);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, required none", kind_act, cyc);
      end else begin
        e = sb.pop_front();
        if (kind_act !== e.kind) begin
          errors++;
          $display("FAIL strobe_kind: got %0d, required %0d", kind_act, e.kind);
        end else if (e.kind == 0) begin
          checks++;
          if (out_rf_write_reg !== e.rd || out_rf_write_data !== e.data || out_commit_idx !== e.idx) begin
            errors++;
            $display("FAIL rf_write: got x%0d=%0h idx %0d, required x%0d=%0h idx %0d",
                     out_rf_write_reg, out_rf_write_data, out_commit_idx, e.rd, e.data, e.idx);
          end
        end else if (e.kind == 1) begin
          checks++;
          if (out_commit_idx !== e.idx) begin
            errors++;
            $display("FAIL store_idx: got %0d, required %0d", out_commit_idx, e.idx);
          end
        end else begin
          checks++;
          if (out_exception_vector !== e.vec || out_exception_pc !== e.pc) begin
            errors++;
            $display("FAIL exception: got vec %0d pc %0h, required vec %0d pc %0h",
                     out_exception_vector, out_exception_pc, e.vec, e.pc);
          end
        end
      end
    end
  end

  function automatic exp_t mk(input int kind, input logic [4:0] rd, input logic [31:0] data,
                              input logic [3:0] idx, input logic [2:0] vec, input logic [31:0] pc);
    exp_t e;
    e.kind = kind; e.rd = rd; e.data = data; e.idx = idx; e.vec = vec; e.pc = pc;
    return e;
  endfunction

  task automatic alloc(input logic [4:0] rd, input logic st, input logic [31:0] pc);
    in_allocate = 1'b1; in_alloc_rd = rd; in_alloc_is_store = st; in_alloc_pc = pc;
    @(negedge clk);
    in_allocate = 1'b0;
  endtask

  task automatic complete(input logic [3:0] idx, input logic [31:0] d, input logic [2:0] e);
    in_complete = 1'b1; in_complete_idx = idx; in_complete_data = d; in_complete_exception = e;
    @(negedge clk);
    in_complete = 1'b0; in_complete_exception = 3'd0;
  endtask

  task automatic flush();
    in_flush = 1'b1;
    @(negedge clk);
    in_flush = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending strobes, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_allocate = 0; in_alloc_rd = 0; in_alloc_is_store = 0; in_alloc_pc = 0;
    in_complete = 0; in_complete_idx = 0; in_complete_data = 0; in_complete_exception = 0;
    in_flush = 0;
    #12;
    checks++;
    if (out_count !== 5'd0 || out_empty !== 1'b1 || out_full !== 1'b0 || out_alloc_idx !== 4'd0) begin
      errors++;
      $display("FAIL reset_status: got count %0d empty %b full %b idx %0d, required 0 1 0 0",
               out_count, out_empty, out_full, out_alloc_idx);
    end
    checks++;
    if (out_rf_write_enable !== 1'b0 || out_store_commit !== 1'b0 || out_exception !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: got we %b st %b exc %b, required 0 0 0",
               out_rf_write_enable, out_store_commit, out_exception);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_alloc_idx !== 4'(i)) begin
        errors++;
        $display("FAIL fill_idx: got %0d, required %0d", out_alloc_idx, i);
      end
      alloc(5'(i + 1), 1'b0, 32'h1000 + 32'(i * 4));
    end
    checks++;
    if (out_full !== 1'b1 || out_count !== 5'd10) begin
      errors++;
      $display("FAIL fill_full: got full %b count %0d, required 1 10", out_full, out_count);
    end
    in_allocate = 1'b1;
    #1;
    checks++;
    if (out_stall !== 1'b1) begin
      errors++;
      $display("FAIL fill_stall: got %b, required 1", out_stall);
    end
    @(negedge clk);
    in_allocate = 1'b0;
    checks++;
    if (out_count !== 5'd10 || out_alloc_idx !== 4'd0) begin
      errors++;
      $display("FAIL fill_overflow: got count %0d idx %0d, required 10 0", out_count, out_alloc_idx);
    end
    flush();
    checks++;
    if (out_count !== 5'd0 || out_empty !== 1'b1) begin
      errors++;
      $display("FAIL fill_flush: got count %0d empty %b, required 0 1", out_count, out_empty);
    end
  endtask

  task automatic test_in_order();
    sb.push_back(mk(0, 5'd5, 32'h11, 4'd0, 3'd0, 32'd0));
    sb.push_back(mk(0, 5'd6, 32'h22, 4'd1, 3'd0, 32'd0));
    sb.push_back(mk(0, 5'd7, 32'h33, 4'd2, 3'd0, 32'd0));
    alloc(5'd5, 1'b0, 32'h0);
    alloc(5'd6, 1'b0, 32'h4);
    alloc(5'd7, 1'b0, 32'h8);
    strobe_cyc.delete();
    complete(4'd2, 32'h33, 3'd0);
    complete(4'd1, 32'h22, 3'd0);
    complete(4'd0, 32'h11, 3'd0);
    wait_drain("in_order");
    checks++;
    if (strobe_cyc.size() != 3) begin
      errors++;
      $display("FAIL in_order_count: got %0d strobes, required 3", strobe_cyc.size());
    end else begin
      checks++;
      if (strobe_cyc[1] != strobe_cyc[0] + 1 || strobe_cyc[2] != strobe_cyc[1] + 1) begin
        errors++;
        $display("FAIL in_order_back_to_back: got cycles %0d %0d %0d, required consecutive",
                 strobe_cyc[0], strobe_cyc[1], strobe_cyc[2]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] idx;
    for (int i = 0; i < 12; i++) begin
      idx = 4'((3 + i) % 10);
      checks++;
      if (out_alloc_idx !== idx) begin
        errors++;
        $display("FAIL wrap_idx: got %0d, required %0d", out_alloc_idx, idx);
      end
      sb.push_back(mk(0, 5'(i + 1), 32'hA000 + 32'(i), idx, 3'd0, 32'd0));
      alloc(5'(i + 1), 1'b0, 32'h2000 + 32'(i));
      complete(idx, 32'hA000 + 32'(i), 3'd0);
    end
    wait_drain("wrap");
    checks++;
    if (out_empty !== 1'b1 || out_count !== 5'd0 || out_alloc_idx !== 4'd5) begin
      errors++;
      $display("FAIL wrap_end: got empty %b count %0d idx %0d, required 1 0 5",
               out_empty, out_count, out_alloc_idx);
    end
  endtask

  task automatic test_store_x0();
    sb.push_back(mk(1, 5'd0, 32'd0, 4'd5, 3'd0, 32'd0));
    alloc(5'd0, 1'b1, 32'h3000);
    alloc(5'd0, 1'b0, 32'h3004);
    complete(4'd5, 32'h55, 3'd0);
    complete(4'd6, 32'h66, 3'd0);
    @(negedge clk);
    checks++;
    if (out_commit_idx !== 4'd6 || out_rf_write_enable !== 1'b0 || out_store_commit !== 1'b0) begin
      errors++;
      $display("FAIL x0_retire: got idx %0d we %b st %b, required 6 0 0",
               out_commit_idx, out_rf_write_enable, out_store_commit);
    end
    wait_drain("store_x0");
    checks++;
    if (out_count !== 5'd0 || out_alloc_idx !== 4'd7) begin
      errors++;
      $display("FAIL store_x0_end: got count %0d idx %0d, required 0 7", out_count, out_alloc_idx);
    end
  endtask

  task automatic test_exception();
    flush();
    alloc(5'd1, 1'b0, 32'h100);
    alloc(5'd2, 1'b0, 32'h104);
    alloc(5'd3, 1'b0, 32'h108);
    sb.push_back(mk(2, 5'd0, 32'd0, 4'd0, 3'd2, 32'h100));
    complete(4'd0, 32'hDEAD, 3'b010);
    @(negedge clk);
    checks++;
    if (out_count !== 5'd0 || out_alloc_idx !== 4'd0 || out_empty !== 1'b1) begin
      errors++;
      $display("FAIL exc_clear: got count %0d idx %0d empty %b, required 0 0 1",
               out_count, out_alloc_idx, out_empty);
    end
    complete(4'd1, 32'h1, 3'd0);
    wait_drain("exception");
    checks++;
    if (out_count !== 5'd0 || out_empty !== 1'b1) begin
      errors++;
      $display("FAIL exc_stale_complete: got count %0d empty %b, required 0 1", out_count, out_empty);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) alloc(5'(i + 1), 1'b0, 32'h400 + 32'(i));
    checks++;
    if (out_count !== 5'd4) begin
      errors++;
      $display("FAIL flush_pre: got count %0d, required 4", out_count);
    end
    in_flush = 1'b1;
    in_allocate = 1'b1;
    @(negedge clk);
    in_flush = 1'b0;
    in_allocate = 1'b0;
    checks++;
    if (out_count !== 5'd0 || out_alloc_idx !== 4'd0 || out_empty !== 1'b1) begin
      errors++;
      $display("FAIL flush_alloc_drop: got count %0d idx %0d empty %b, required 0 0 1",
               out_count, out_alloc_idx, out_empty);
    end
    // Flush coinciding with a faulting head still reports the exception
    alloc(5'd4, 1'b0, 32'h200);
    sb.push_back(mk(2, 5'd0, 32'd0, 4'd0, 3'd5, 32'h200));
    complete(4'd0, 32'hBEEF, 3'b101);
    flush();
    wait_drain("flush_exc");
    checks++;
    if (out_count !== 5'd0) begin
      errors++;
      $display("FAIL flush_exc_count: got %0d, required 0", out_count);
    end
  endtask

  task automatic test_async_reset();
    alloc(5'd9, 1'b0, 32'h300);
    complete(4'd0, 32'h99, 3'd0);
    @(posedge clk);
    #1;
    checks++;
    if (out_rf_write_enable !== 1'b1 || out_rf_write_reg !== 5'd9) begin
      errors++;
      $display("FAIL areset_pre: got we %b reg %0d, required 1 9", out_rf_write_enable, out_rf_write_reg);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (out_rf_write_enable !== 1'b0 || out_count !== 5'd0 || out_empty !== 1'b1) begin
      errors++;
      $display("FAIL areset_clear: got we %b count %0d empty %b, required 0 0 1",
               out_rf_write_enable, out_count, out_empty);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_in_order();
    test_wrap();
    test_store_x0();
    test_exception();
    test_flush();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_queue: got %0d pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_controller.md
Name: rob_controller

Overview:
- Reorder-buffer controller sitting between decode, the execute/memory completion paths and the register file write port.
- Hands out in-order ROB indices to decoded instructions that request allocation.
- Records completion results by index and retires the oldest entry in program order: one RF write per cycle, or one store-release pulse per cycle.
- Turns a completed-with-exception head, or an external taken-branch flush, into a full buffer wipe.

Parameters:
ENTRIES, 10, number of ROB entries (2..16)
IDX_W, 4, index width; must satisfy 2^IDX_W >= ENTRIES

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_allocate  in  1  decode requests a new entry this cycle
in_alloc_rd  in  5  destination register of the allocating instruction
in_alloc_is_store  in  1  allocating instruction is a store
in_alloc_pc  in  32  PC of the allocating instruction
out_alloc_idx  out  IDX_W  index granted (the tail pointer, combinational)
out_full  out  1  count == ENTRIES
out_stall  out  1  in_allocate & out_full
out_empty  out  1  count == 0
out_count  out  IDX_W+1  occupied entries
in_complete  in  1  a result is being written back to the ROB
in_complete_idx  in  IDX_W  target entry
in_complete_data  in  32  result value
in_complete_exception  in  3  exception vector (0 = none)
in_flush  in  1  taken branch; discard all entries
out_rf_write_enable  out  1  registered RF write strobe
out_rf_write_reg  out  5  registered RF destination
out_rf_write_data  out  32  registered RF data
out_store_commit  out  1  registered one-cycle store-release pulse
out_commit_idx  out  IDX_W  index of the entry retired
out_exception  out  1  registered one-cycle exception pulse
out_exception_vector  out  3  vector of the faulting entry
out_exception_pc  out  32  PC of the faulting entry

Behaviour:
- Entry state: valid, done, rd, is_store, pc, data, exc.
- Pointers: head and tail, each wrapping from ENTRIES-1 to 0 (not a power-of-2 wrap).
- Reset (reset=0, asynchronous):
  - head = tail = count = 0; all valid/done = 0.
  - All registered outputs = 0.
  - out_empty = 1, out_full = 0, out_alloc_idx = 0.
- Allocate (edge, in_allocate & !out_full & !clear):
  - Entry[tail] gets valid = 1, done = 0, rd, is_store, pc.
  - tail advances.
  - When full, the request is ignored even if a commit occurs in the same cycle; decode holds while out_stall = 1.
- Complete (edge, in_complete & entry[idx].valid):
  - done = 1; data and exc are written.
  - Completion to an invalid entry is ignored.
- Commit evaluation (edge): head entry valid & done.
  - exc == 0, normal retire:
    - head advances and count decrements.
    - Next cycle: out_commit_idx = head.
    - out_rf_write_enable = !is_store & (rd != 0), with out_rf_write_reg/out_rf_write_data from the entry.
    - out_store_commit = is_store.
  - exc != 0:
    - Next cycle: out_exception = 1 with vector and pc of the head entry. No RF write, no store pulse.
    - Internal clear in the same edge.
  - Latency: a head entry's completion is accepted at edge N, retire is evaluated at edge N+1, and outputs are visible in the cycle after edge N+1.
  - At most one retire per cycle. All strobes are single-cycle unless the next entry also retires.
- Clear (in_flush, or head exception):
  - All valid/done = 0; head = tail = count = 0.
  - Allocate, complete and normal commit in that cycle are discarded.
  - in_flush asserted together with a head exception still emits out_exception.
- count:
  - +1 on an accepted allocate, -1 on a normal retire, unchanged when both occur.
  - Never exceeds ENTRIES and never underflows.
- Allocate and complete to the head entry in the same cycle: allowed (the entries are distinct unless the buffer is empty, in which case the complete is ignored).
- Reset mid-operation: immediate return to the reset state; any pending strobes are dropped.

Test Plan:
- Fill and full: 10 allocates with no completes → out_alloc_idx steps 0..9, out_full = 1 after the 10th; an 11th in_allocate → out_stall = 1 and count stays 10.
- In-order retire: allocate rd = 5, 6, 7 (idx 0, 1, 2); complete idx 2 then 1 then 0 with data 0x33/0x22/0x11 → RF writes x5 = 0x11, x6 = 0x22, x7 = 0x33 on consecutive cycles, out_commit_idx = 0, 1, 2.
- Wrap-around: cycle 12 entries through the buffer with immediate completes → the index after 9 is 0, out_empty = 1 at the end, no dropped or duplicated writes.
- Store and x0: a store entry (rd = 0) and an rd = 0 ALU entry → the store gives out_store_commit = 1 with no RF write; the x0 entry gives neither strobe but the head advances.
- Exception: 3 entries, complete head idx 0 with exc = 3'b010, pc = 0x100 → out_exception = 1, vector = 2, pc = 0x100; count = 0 and out_alloc_idx = 0 the next cycle; a later complete to idx 1 is ignored.
- Flush and async reset: in_flush with 4 entries plus a simultaneous allocate → count = 0 and the allocate is dropped; pulling reset low mid-commit clears out_rf_write_enable without waiting for a clock edge.
